twiddle_mult: RTL and testbench

- Streaming twiddle-multiply stage between the FFT butterfly output and the next butterfly stage.
- Per accepted sample, it generates the twiddle index and drives the external const_rom (en/addr).
- It delays the sample to match the ROM's 2-cycle read latency, then performs a pipelined Q15 complex multiply with rounding and saturation.
- No backpressure: pure valid-qualified stream.

---
 rtl/twiddle_mult.sv | 118 +++++++++++
 tb/tb_twiddle_mult.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_mult.sv
// Streaming twiddle-multiply stage: drives the twiddle ROM per accepted sample, aligns the
// sample to the ROM read latency, then does a pipelined Q15 complex multiply with round/saturate.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module twiddle_mult #(
  parameter int STRIDE = 1,
  parameter int DW     = `DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [2*DW-1:0] in_data,
  output logic            rom_en,
  output logic [3:0]      rom_addr,
  input  logic [2*DW-1:0] rom_data,
  output logic            out_valid,
  output logic            out_sof,
  output logic [2*DW-1:0] out_data
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam logic [3:0] STEP = 4'(STRIDE);
  localparam logic signed [SW-1:0] RND     = SW'(1) << (DW - 2);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (DW - 1)));

  logic [3:0]             k;
  logic                   v1, v2, v3, v4;
  logic                   sof1, sof2, sof3, sof4;
  logic [PW-1:0]          d1, d2;
  logic signed [DW-1:0]   xr, xi, wr, wi;
  logic signed [PW-1:0]   pr1, pr2, pi1, pi2;
  logic signed [SW-1:0]   sr, si;

  // Combinational address so the ROM registers it on the same edge that accepts the sample.
  assign rom_en   = in_valid;
  assign rom_addr = in_sof ? 4'd0 : k * STEP;

  assign xr = d2[PW-1:DW];
  assign xi = d2[DW-1:0];
  assign wr = rom_data[PW-1:DW];
  assign wi = rom_data[DW-1:0];

  function automatic logic [DW-1:0] round_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = (v + RND) >>> (DW - 1);
    if (t > SAT_MAX)
      return {1'b0, {(DW-1){1'b1}}};
    else if (t < SAT_MIN)
      return {1'b1, {(DW-1){1'b0}}};
    else
      return t[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      k <= 4'd0;
    else if (in_valid)
      k <= in_sof ? 4'd1 : k + 4'd1;
  end

  // Two alignment stages match the ROM read latency; later stages form the multiply pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      sof1      <= 1'b0;
      sof2      <= 1'b0;
      sof3      <= 1'b0;
      sof4      <= 1'b0;
      d1        <= '0;
      d2        <= '0;
      pr1       <= '0;
      pr2       <= '0;
      pi1       <= '0;
      pi2       <= '0;
      sr        <= '0;
      si        <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= '0;
    end else begin
      v1        <= in_valid;
      sof1      <= in_valid & in_sof;
      v2        <= v1;
      sof2      <= sof1;
      v3        <= v2;
      sof3      <= sof2;
      v4        <= v3;
      sof4      <= sof3;
      out_valid <= v4;
      out_sof   <= sof4;
      if (in_valid)
        d1 <= in_data;
      if (v1)
        d2 <= d1;
      if (v2) begin
        pr1 <= PW'(xr) * PW'(wr);
        pr2 <= PW'(xi) * PW'(wi);
        pi1 <= PW'(xr) * PW'(wi);
        pi2 <= PW'(xi) * PW'(wr);
      end
      if (v3) begin
        sr <= SW'(pr1) - SW'(pr2);
        si <= SW'(pi1) + SW'(pi2);
      end
      if (v4)
        out_data <= {round_sat(sr), round_sat(si)};
    end
  end

endmodule

// File: tb/tb_twiddle_mult.sv
// Table-driven bench for twiddle_mult: models the 2-cycle twiddle ROM, checks ROM addressing for
// STRIDE 1 and 3, and compares every output cycle against a Q15 complex-multiply model.
module tb_twiddle_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [31:0] in_data;
  logic        rom_en, rom_en3;
  logic [3:0]  rom_addr, rom_addr3;
  logic [31:0] rom_data;
  logic        out_valid, out_valid3;
  logic        out_sof, out_sof3;
  logic [31:0] out_data, out_data3;

  int checks = 0;
  int failures = 0;

  // Q15 twiddles: wr = cos(pi*k/16), wi = -sin(pi*k/16); entry 8 uses full-scale -1.
  int wr_tab[16] = '{32767, 32137, 30273, 27245, 23170, 18204, 12539, 6393,
                     0, -6393, -12539, -18204, -23170, -27245, -30273, -32137};
  int wi_tab[16] = '{0, -6393, -12539, -18204, -23170, -27245, -30273, -32137,
                     -32768, -32137, -30273, -27245, -23170, -18204, -12539, -6393};

  typedef struct {
    logic        valid;
    logic        sof;
    logic [31:0] data;
    logic [3:0]  a1;
    logic [3:0]  a3;
    logic        chk;
    logic [31:0] hand;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        sof;
    logic [31:0] model;
    logic        chk;
    logic [31:0] hand;
  } exp_t;

  vec_t vecs[$];
  exp_t exq[$];

  twiddle_mult #(.STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data)
  );

  twiddle_mult #(.STRIDE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(32'h0000_0000),
    .out_valid(out_valid3), .out_sof(out_sof3), .out_data(out_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // const_rom model: address register then output register.
  logic [3:0] rom_addr_q = 4'd0;
  always @(posedge clk) begin
    if (rom_en)
      rom_addr_q <= rom_addr;
    rom_data <= {16'(wr_tab[rom_addr_q]), 16'(wi_tab[rom_addr_q])};
  end

  function automatic logic [15:0] rndSat(input longint v);
    longint t;
    t = (v + 64'sd16384) >>> 15;
    if (t > 32767) return 16'h7FFF;
    if (t < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  function automatic logic [31:0] modelOut(input logic [31:0] x, input logic [3:0] idx);
    longint xr, xi, wr, wi;
    xr = longint'($signed(x[31:16]));
    xi = longint'($signed(x[15:0]));
    wr = longint'(wr_tab[idx]);
    wi = longint'(wi_tab[idx]);
    return {rndSat(xr * wr - xi * wi), rndSat(xr * wi + xi * wr)};
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic v, input logic s, input logic [31:0] d, input logic [3:0] a1,
                        input logic [3:0] a3, input logic c, input logic [31:0] h);
    vec_t r;
    r.valid = v; r.sof = s; r.data = d; r.a1 = a1; r.a3 = a3; r.chk = c; r.hand = h;
    vecs.push_back(r);
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) addVec(1'b0, 1'b0, 32'h0, 4'd0, 4'd0, 1'b0, 32'h0);
  endtask

  // Output seen now belongs to the input applied five cycles earlier.
  task automatic checkOutput();
    exp_t e;
    if (exq.size() >= 5) begin
      e = exq.pop_front();
      checkValue("out_valid", out_valid, e.valid);
      checkValue("out_valid_s3", out_valid3, e.valid);
      if (e.valid) begin
        checkValue("out_sof", out_sof, e.sof);
        checkValue("out_sof_s3", out_sof3, e.sof);
        checkValue("out_data", out_data, e.model);
        checkValue("out_data_s3", out_data3, 32'h0);
        if (e.chk) checkValue("out_data_hand", out_data, e.hand);
      end
    end else begin
      checkValue("out_valid_idle", out_valid, 1'b0);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    checkOutput();
    in_valid = v.valid;
    in_sof   = v.sof;
    in_data  = v.data;
    #1;
    checkValue("rom_en", rom_en, v.valid);
    checkValue("rom_en_s3", rom_en3, v.valid);
    if (v.valid) begin
      checkValue("rom_addr", rom_addr, v.a1);
      checkValue("rom_addr_s3", rom_addr3, v.a3);
    end
    e.valid = v.valid;
    e.sof   = v.valid & v.sof;
    e.model = modelOut(v.data, v.a1);
    e.chk   = v.chk;
    e.hand  = v.hand;
    exq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic resetMidStream();
    checkOutput();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkValue("async_rst_valid", out_valid, 1'b0);
    checkValue("async_rst_sof", out_sof, 1'b0);
    checkValue("async_rst_data", out_data, 32'h0);
    exq.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 32'h0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkValue("reset_out_valid", out_valid, 1'b0);
    checkValue("reset_out_sof", out_sof, 1'b0);
    checkValue("reset_out_data", out_data, 32'h0);
    checkValue("reset_rom_addr", rom_addr, 4'd0);

    // 20-sample sweep from sof: identity at k=0, saturation at k=8, wrap back to 0 at sample 16.
    addVec(1, 1, 32'h4000_0000,  0,  0, 1, 32'h4000_0000);
    addVec(1, 0, 32'h2000_1000,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h7FFF_7FFF,  2,  6, 0, 32'h0);
    addVec(1, 0, 32'h8000_0000,  3,  9, 0, 32'h0);
    addVec(1, 0, 32'hC000_4000,  4, 12, 0, 32'h0);
    addVec(1, 0, 32'h1234_5678,  5, 15, 0, 32'h0);
    addVec(1, 0, 32'hEDCB_A987,  6,  2, 0, 32'h0);
    addVec(1, 0, 32'h0100_FF00,  7,  5, 0, 32'h0);
    addVec(1, 0, 32'h8000_8000,  8,  8, 1, 32'h8000_7FFF);
    addVec(1, 0, 32'h7FFF_8000,  9, 11, 0, 32'h0);
    addVec(1, 0, 32'h0001_FFFF, 10, 14, 0, 32'h0);
    addVec(1, 0, 32'h3333_CCCC, 11,  1, 0, 32'h0);
    addVec(1, 0, 32'h5A82_A57E, 12,  4, 0, 32'h0);
    addVec(1, 0, 32'hFFFF_0001, 13,  7, 0, 32'h0);
    addVec(1, 0, 32'h6000_E000, 14, 10, 0, 32'h0);
    addVec(1, 0, 32'h0000_7FFF, 15, 13, 0, 32'h0);
    addVec(1, 0, 32'h4000_4000,  0,  0, 1, 32'h4000_4000);
    addVec(1, 0, 32'h8001_7FFF,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h2468_ACE0,  2,  6, 0, 32'h0);
    addVec(1, 0, 32'h7000_9000,  3,  9, 0, 32'h0);
    // Gapped frame: valid 1,0,0,1,1,0,1.
    addVec(1, 1, 32'h1111_2222,  0,  0, 0, 32'h0);
    addIdle(2);
    addVec(1, 0, 32'h3333_4444,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h5555_6666,  2,  6, 0, 32'h0);
    addIdle(1);
    addVec(1, 0, 32'h7777_8888,  3,  9, 0, 32'h0);
    // Frame restarted by sof on its 7th sample.
    addVec(1, 1, 32'h0ABC_0DEF,  0,  0, 0, 32'h0);
    addVec(1, 0, 32'h1000_2000,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h2000_1000,  2,  6, 0, 32'h0);
    addVec(1, 0, 32'h3000_F000,  3,  9, 0, 32'h0);
    addVec(1, 0, 32'h4000_E000,  4, 12, 0, 32'h0);
    addVec(1, 0, 32'h5000_D000,  5, 15, 0, 32'h0);
    addVec(1, 1, 32'h4000_0000,  0,  0, 1, 32'h4000_0000);
    addVec(1, 0, 32'h7000_B000,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h7FFF_A000,  2,  6, 0, 32'h0);
    addIdle(5);
    // Samples in flight when reset hits mid-stream.
    addVec(1, 1, 32'h4000_0000,  0,  0, 1, 32'h4000_0000);
    addVec(1, 0, 32'h2000_2000,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h1000_1000,  2,  6, 0, 32'h0);
    addVec(1, 0, 32'h0800_0800,  3,  9, 0, 32'h0);
    addIdle(1);

    foreach (vecs[i]) applyStimulus(vecs[i]);
    resetMidStream();

    vecs.delete();
    addIdle(1);
    addVec(1, 1, 32'h4000_0000,  0,  0, 1, 32'h4000_0000);
    addVec(1, 0, 32'h7FFF_0000,  1,  3, 0, 32'h0);
    addVec(1, 0, 32'h0000_7FFF,  2,  6, 0, 32'h0);
    addIdle(6);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
